// File: rtl/twiddle_seq_ctrl_if.sv
// Descriptor bus between the twiddle sequencer and the twiddle-multiply stage.
// The master side is the sequencer: it takes the start/inverse request and the
// downstream READY, and drives one butterfly descriptor per transfer.
interface twiddle_seq_ctrl_if #(
  parameter int LOG2N = 6
);
  logic             start;
  logic             inv;
  logic             ready;
  logic             valid;
  logic [2:0]       stage;
  logic [LOG2N-2:0] bfly;
  logic [LOG2N-2:0] twaddr;
  logic             bypass;
  logic [2:0]       typesel;
  logic             twconj;
  logic             busy;
  logic             done;

  modport master (
    input  start, inv, ready,
    output valid, stage, bfly, twaddr, bypass, typesel, twconj, busy, done
  );

  modport slave (
    output start, inv, ready,
    input  valid, stage, bfly, twaddr, bypass, typesel, twconj, busy, done
  );
endinterface

// File: rtl/twiddle_seq_ctrl.sv
// Twiddle-multiply sequencer for a radix-2 DIF FFT.
// Walks every stage and every butterfly within the stage, issuing one
// descriptor per transfer. Each descriptor carries the twiddle exponent and
// tells the datapath whether the twiddle is trivial (x1 or x-/+j, handled by
// the bypass unit) or must go through the complex multiplier. A fixed number
// of idle cycles is inserted between stages so the pipeline can drain.
module twiddle_seq_ctrl #(
  parameter int LOG2N     = 6,
  parameter int STAGE_GAP = 4
) (
  input  logic                clk,
  input  logic                rst,
  twiddle_seq_ctrl_if.master  bus
);

  localparam int BW   = LOG2N - 1;
  localparam int GAPW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [BW-1:0]   LAST_BFLY  = '1;
  localparam logic [2:0]      LAST_STAGE = 3'(LOG2N - 1);
  localparam logic [BW-1:0]   QUARTER    = BW'(1 << (BW - 1));
  localparam logic [GAPW-1:0] GAP_LAST   = GAPW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      stage_q, stage_d;
  logic [BW-1:0]   bfly_q, bfly_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic            inv_q, inv_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   twaddr_q, twaddr_d;
  logic            bypass_q, bypass_d;
  logic [2:0]      typesel_q, typesel_d;

  logic            load_desc;
  logic            clear_desc;
  logic [BW-1:0]   exp_next;

  // Next-state logic: counter walk, stage gaps, and descriptor classification
  // computed from the counters the registers are about to take, so the
  // descriptor always lines up with STAGE/BFLY in the same cycle.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    bfly_d     = bfly_q;
    gap_d      = gap_q;
    inv_d      = inv_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_desc  = 1'b0;
    clear_desc = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          stage_d   = '0;
          bfly_d    = '0;
          inv_d     = bus.inv;
          valid_d   = 1'b1;
          busy_d    = 1'b1;
          load_desc = 1'b1;
        end
      end
      RUN: begin
        if (valid_q && bus.ready) begin
          if (bfly_q != LAST_BFLY) begin
            bfly_d    = bfly_q + BW'(1);
            load_desc = 1'b1;
          end else if (stage_q != LAST_STAGE) begin
            bfly_d    = '0;
            stage_d   = stage_q + 3'd1;
            load_desc = 1'b1;
            if (STAGE_GAP > 0) begin
              state_d = GAP;
              valid_d = 1'b0;
              gap_d   = '0;
            end
          end else begin
            state_d    = FINISH;
            stage_d    = '0;
            bfly_d     = '0;
            valid_d    = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            clear_desc = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = RUN;
          valid_d = 1'b1;
        end else begin
          gap_d = gap_q + GAPW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    exp_next = bfly_d << stage_d;

    twaddr_d  = twaddr_q;
    bypass_d  = bypass_q;
    typesel_d = typesel_q;
    if (clear_desc) begin
      twaddr_d  = '0;
      bypass_d  = 1'b0;
      typesel_d = 3'b000;
    end else if (load_desc) begin
      twaddr_d = exp_next;
      if (exp_next == '0) begin
        bypass_d  = 1'b1;
        typesel_d = 3'b000;
      end else if (exp_next == QUARTER) begin
        bypass_d  = 1'b1;
        typesel_d = inv_d ? 3'b110 : 3'b101;
      end else begin
        bypass_d  = 1'b0;
        typesel_d = 3'b000;
      end
    end
  end

  // State and every output register; reset clears the whole descriptor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      bfly_q    <= '0;
      gap_q     <= '0;
      inv_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      twaddr_q  <= '0;
      bypass_q  <= 1'b0;
      typesel_q <= 3'b000;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
      gap_q     <= gap_d;
      inv_q     <= inv_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      twaddr_q  <= twaddr_d;
      bypass_q  <= bypass_d;
      typesel_q <= typesel_d;
    end
  end

  assign bus.valid   = valid_q;
  assign bus.stage   = stage_q;
  assign bus.bfly    = bfly_q;
  assign bus.twaddr  = twaddr_q;
  assign bus.bypass  = bypass_q;
  assign bus.typesel = typesel_q;
  assign bus.twconj  = inv_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
